// File: rtl/shift_rot_pkg.sv
// Shared definitions for the multi-mode sequential shifter: mode codes,
// FSM state encoding and the per-cycle step-size helper.
package shift_rot_pkg;

   localparam logic [2:0] MODE_ROR = 3'd0;
   localparam logic [2:0] MODE_ROL = 3'd1;
   localparam logic [2:0] MODE_LSR = 3'd2;
   localparam logic [2:0] MODE_LSL = 3'd3;
   localparam logic [2:0] MODE_ASR = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int min_step(input int remaining, input int step);
      return (remaining < step) ? remaining : step;
   endfunction

endpackage

// File: rtl/shift_rot_step.sv
// One combinational move of a word by k positions in the selected mode.
// With SHIFT_ROT_SOUT_EN defined it also reports the last bit moved out.
module shift_rot_step
   import shift_rot_pkg::*;
#(
   parameter int W  = 16,
   parameter int AW = 4
) (
   input  logic [W-1:0]  i_word,
   input  logic [2:0]    i_mode,
   input  logic [AW-1:0] i_k,
`ifdef SHIFT_ROT_SOUT_EN
   output logic          o_out_bit,
   output logic          o_out_vld,
`endif
   output logic [W-1:0]  o_word
);

   logic [2*W-1:0] w_dbl;
   logic [2*W-1:0] w_ror;
   logic [2*W-1:0] w_rol;

   // Rotations fall out of shifting a doubled copy of the word.
   assign w_dbl = {i_word, i_word};
   assign w_ror = w_dbl >> i_k;
   assign w_rol = w_dbl << i_k;

   always_comb begin
      o_word = i_word;
      case (i_mode)
         MODE_ROR: o_word = w_ror[W-1:0];
         MODE_ROL: o_word = w_rol[2*W-1:W];
         MODE_LSR: o_word = i_word >> i_k;
         MODE_LSL: o_word = i_word << i_k;
         MODE_ASR: o_word = $signed(i_word) >>> i_k;
         default:  o_word = i_word;
      endcase
   end

`ifdef SHIFT_ROT_SOUT_EN
   logic [AW-1:0] w_km1;
   logic [W-1:0]  w_rsh;
   logic [W-1:0]  w_lsh;

   // Moving by k-1 parks the last departing bit at the edge it leaves from.
   assign w_km1 = i_k - AW'(1);
   assign w_rsh = i_word >> w_km1;
   assign w_lsh = i_word << w_km1;

   always_comb begin
      o_out_bit = 1'b0;
      o_out_vld = 1'b0;
      case (i_mode)
         MODE_ROR, MODE_LSR, MODE_ASR: begin
            o_out_bit = w_rsh[0];
            o_out_vld = 1'b1;
         end
         MODE_ROL, MODE_LSL: begin
            o_out_bit = w_lsh[W-1];
            o_out_vld = 1'b1;
         end
         default: begin
            o_out_bit = 1'b0;
            o_out_vld = 1'b0;
         end
      endcase
   end
`endif

endmodule

// File: rtl/shift_rot_seq.sv
// Sequential shifter: loads a word, then rotates/shifts it by amt positions,
// STEP per cycle, with a start/busy/done handshake. Optional sout via SHIFT_ROT_SOUT_EN.
module shift_rot_seq
   import shift_rot_pkg::*;
#(
   parameter  int bit_width = 16,
   parameter  int STEP      = 1,
   localparam int AW        = $clog2(bit_width)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld,
   input  logic                 start,
   input  logic [2:0]           mode,
   input  logic [AW-1:0]        amt,
   input  logic [bit_width-1:0] data_in,
`ifdef SHIFT_ROT_SOUT_EN
   output logic                 sout,
`endif
   output logic [bit_width-1:0] data_out,
   output logic                 busy,
   output logic                 done
);

   localparam logic [AW-1:0] MAX_AMT = AW'(bit_width - 1);

   state_t               r_state;
   state_t               w_next_state;
   logic [bit_width-1:0] r_data;
   logic [2:0]           r_mode;
   logic [AW-1:0]        r_rem;
   logic [AW-1:0]        w_amt;
   logic [AW-1:0]        w_k;
   logic [bit_width-1:0] w_step_word;

   // Only reachable for non-power-of-two widths.
   assign w_amt = (amt > MAX_AMT) ? MAX_AMT : amt;
   assign w_k   = AW'(min_step(int'(r_rem), STEP));

`ifdef SHIFT_ROT_SOUT_EN
   logic r_sout;
   logic w_out_bit;
   logic w_out_vld;
   assign sout = r_sout;
`endif

   shift_rot_step #(.W(bit_width), .AW(AW)) u_step (
      .i_word    (r_data),
      .i_mode    (r_mode),
      .i_k       (w_k),
`ifdef SHIFT_ROT_SOUT_EN
      .o_out_bit (w_out_bit),
      .o_out_vld (w_out_vld),
`endif
      .o_word    (w_step_word)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = (w_amt == '0) ? DONE : BUSY;
         BUSY:    if (r_rem == w_k) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == BUSY);
      done = (r_state == DONE);
   end

   assign data_out = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_mode <= '0;
         r_rem  <= '0;
`ifdef SHIFT_ROT_SOUT_EN
         r_sout <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_data <= ld ? data_in : r_data;
                  r_mode <= mode;
                  r_rem  <= w_amt;
               end else if (ld) begin
                  r_data <= data_in;
               end
            end
            BUSY: begin
               r_data <= w_step_word;
               r_rem  <= r_rem - w_k;
`ifdef SHIFT_ROT_SOUT_EN
               if (w_out_vld) r_sout <= w_out_bit;
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_rot_seq.sv
// Directed bench for shift_rot_seq: three instances (STEP=1,2,4) share stimulus;
// each scenario task checks the instance it targets against hand-computed values.
module tb_shift_rot_seq;

   logic        clk = 1'b0;
   logic        rst, ld, start;
   logic [2:0]  mode;
   logic [3:0]  amt;
   logic [15:0] data_in;
   logic [15:0] do1, do2, do4;
   logic        b1, b2, b4, d1, d2, d4;
`ifdef SHIFT_ROT_SOUT_EN
   logic        s1, s2, s4;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_rot_seq #(.bit_width(16), .STEP(1)) u_s1 (
      .clk(clk), .rst(rst), .ld(ld), .start(start), .mode(mode), .amt(amt),
      .data_in(data_in),
`ifdef SHIFT_ROT_SOUT_EN
      .sout(s1),
`endif
      .data_out(do1), .busy(b1), .done(d1));

   shift_rot_seq #(.bit_width(16), .STEP(2)) u_s2 (
      .clk(clk), .rst(rst), .ld(ld), .start(start), .mode(mode), .amt(amt),
      .data_in(data_in),
`ifdef SHIFT_ROT_SOUT_EN
      .sout(s2),
`endif
      .data_out(do2), .busy(b2), .done(d2));

   shift_rot_seq #(.bit_width(16), .STEP(4)) u_s4 (
      .clk(clk), .rst(rst), .ld(ld), .start(start), .mode(mode), .amt(amt),
      .data_in(data_in),
`ifdef SHIFT_ROT_SOUT_EN
      .sout(s4),
`endif
      .data_out(do4), .busy(b4), .done(d4));

   // Inputs change and outputs are sampled on the falling edge.
   task automatic idle_inputs();
      ld = 1'b0; start = 1'b0; mode = 3'd0; amt = 4'd0; data_in = 16'h0000;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((b1 | b2 | b4 | d1 | d2 | d4) && n < 64) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (b1 | b2 | b4 | d1 | d2 | d4) begin
         failures++;
         $display("FAIL wait_idle: still active after %0d cycles, required idle", n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ld = 1'b1; start = 1'b0; mode = 3'd0; amt = 4'd0; data_in = 16'hBEEF;
      @(negedge clk);
      @(negedge clk);
      checks += 9;
      if (do1 !== 16'h0000) begin failures++; $display("FAIL reset_do1: got %h want 0000", do1); end
      if (do2 !== 16'h0000) begin failures++; $display("FAIL reset_do2: got %h want 0000", do2); end
      if (do4 !== 16'h0000) begin failures++; $display("FAIL reset_do4: got %h want 0000", do4); end
      if (b1 !== 1'b0) begin failures++; $display("FAIL reset_b1: got %b want 0", b1); end
      if (b2 !== 1'b0) begin failures++; $display("FAIL reset_b2: got %b want 0", b2); end
      if (b4 !== 1'b0) begin failures++; $display("FAIL reset_b4: got %b want 0", b4); end
      if (d1 !== 1'b0) begin failures++; $display("FAIL reset_d1: got %b want 0", d1); end
      if (d2 !== 1'b0) begin failures++; $display("FAIL reset_d2: got %b want 0", d2); end
      if (d4 !== 1'b0) begin failures++; $display("FAIL reset_d4: got %b want 0", d4); end
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_ror_step1();
      ld = 1'b1; start = 1'b1; data_in = 16'h8001; mode = 3'd0; amt = 4'd1;
      @(negedge clk);
      idle_inputs();
      checks += 2;
      if (b1 !== 1'b1) begin failures++; $display("FAIL ror1_busy: got %b want 1", b1); end
      if (d1 !== 1'b0) begin failures++; $display("FAIL ror1_nodone: got %b want 0", d1); end
      @(negedge clk);
      checks += 3;
      if (d1 !== 1'b1) begin failures++; $display("FAIL ror1_done: got %b want 1", d1); end
      if (b1 !== 1'b0) begin failures++; $display("FAIL ror1_busy_end: got %b want 0", b1); end
      if (do1 !== 16'hC000) begin failures++; $display("FAIL ror1_data: got %h want c000", do1); end
      @(negedge clk);
      checks += 2;
      if (d1 !== 1'b0) begin failures++; $display("FAIL ror1_done_once: got %b want 0", d1); end
      if (do1 !== 16'hC000) begin failures++; $display("FAIL ror1_hold: got %h want c000", do1); end
      wait_idle();
   endtask

   task automatic test_rol_step4();
      ld = 1'b1; data_in = 16'h1234;
      @(negedge clk);
      ld = 1'b0; start = 1'b1; mode = 3'd1; amt = 4'd8; data_in = 16'hFFFF;
      @(negedge clk);
      idle_inputs();
      checks += 2;
      if (b4 !== 1'b1) begin failures++; $display("FAIL rol4_busy1: got %b want 1", b4); end
      if (do4 !== 16'h1234) begin failures++; $display("FAIL rol4_operand: got %h want 1234", do4); end
      @(negedge clk);
      checks += 2;
      if (b4 !== 1'b1) begin failures++; $display("FAIL rol4_busy2: got %b want 1", b4); end
      if (do4 !== 16'h2341) begin failures++; $display("FAIL rol4_mid: got %h want 2341", do4); end
      @(negedge clk);
      checks += 3;
      if (d4 !== 1'b1) begin failures++; $display("FAIL rol4_done: got %b want 1", d4); end
      if (b4 !== 1'b0) begin failures++; $display("FAIL rol4_busy_end: got %b want 0", b4); end
      if (do4 !== 16'h3412) begin failures++; $display("FAIL rol4_final: got %h want 3412", do4); end
      @(negedge clk);
      checks++;
      if (d4 !== 1'b0) begin failures++; $display("FAIL rol4_done_once: got %b want 0", d4); end
      wait_idle();
   endtask

   task automatic test_asr_lsr_step2();
      logic [2:0]  modes [2];
      logic [15:0] exps  [2];
      modes[0] = 3'd4; exps[0] = 16'hFF80;
      modes[1] = 3'd2; exps[1] = 16'h0780;
      for (int t = 0; t < 2; t++) begin
         int busy_cnt = 0;
         int n = 0;
         ld = 1'b1; start = 1'b1; data_in = 16'hF000; mode = modes[t]; amt = 4'd5;
         @(negedge clk);
         idle_inputs();
         while (!d2 && n < 20) begin
            if (b2) busy_cnt++;
            @(negedge clk);
            n++;
         end
         checks += 3;
         if (d2 !== 1'b1) begin failures++; $display("FAIL sh2_done[%0d]: got %b want 1", t, d2); end
         if (busy_cnt != 3) begin failures++; $display("FAIL sh2_busy_cycles[%0d]: got %0d want 3", t, busy_cnt); end
         if (do2 !== exps[t]) begin failures++; $display("FAIL sh2_final[%0d]: got %h want %h", t, do2, exps[t]); end
         wait_idle();
      end
   endtask

   task automatic test_amt_zero();
      ld = 1'b1; start = 1'b1; data_in = 16'hA5A5; mode = 3'd0; amt = 4'd0;
      @(negedge clk);
      idle_inputs();
      checks += 4;
      if (d1 !== 1'b1) begin failures++; $display("FAIL amt0_done: got %b want 1", d1); end
      if (b1 !== 1'b0) begin failures++; $display("FAIL amt0_busy: got %b want 0", b1); end
      if (do1 !== 16'hA5A5) begin failures++; $display("FAIL amt0_data: got %h want a5a5", do1); end
      if (do4 !== 16'hA5A5) begin failures++; $display("FAIL amt0_data4: got %h want a5a5", do4); end
      @(negedge clk);
      checks++;
      if (d1 !== 1'b0) begin failures++; $display("FAIL amt0_done_once: got %b want 0", d1); end
      wait_idle();
   endtask

   task automatic test_ignore_in_busy();
      int busy_cnt = 0;
      int n = 0;
      ld = 1'b1; start = 1'b1; data_in = 16'h00FF; mode = 3'd3; amt = 4'd4;
      @(negedge clk);
      idle_inputs();
      if (b1) busy_cnt++;
      @(negedge clk);
      if (b1) busy_cnt++;
      ld = 1'b1; start = 1'b1; data_in = 16'hFFFF; mode = 3'd2; amt = 4'd1;
      @(negedge clk);
      idle_inputs();
      n = 0;
      while (!d1 && n < 20) begin
         if (b1) busy_cnt++;
         @(negedge clk);
         n++;
      end
      checks += 3;
      if (d1 !== 1'b1) begin failures++; $display("FAIL ign_done: got %b want 1", d1); end
      if (busy_cnt != 4) begin failures++; $display("FAIL ign_busy_cycles: got %0d want 4", busy_cnt); end
      if (do1 !== 16'h0FF0) begin failures++; $display("FAIL ign_final: got %h want 0ff0", do1); end
      wait_idle();
   endtask

   task automatic test_reset_mid_busy();
      int done_seen = 0;
      ld = 1'b1; start = 1'b1; data_in = 16'h1234; mode = 3'd0; amt = 4'd12;
      @(negedge clk);
      idle_inputs();
      repeat (4) @(negedge clk);
      checks++;
      if (b1 !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b want 1", b1); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 3;
      if (do1 !== 16'h0000) begin failures++; $display("FAIL rstmid_data: got %h want 0000", do1); end
      if (b1 !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", b1); end
      if (d1 !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b want 0", d1); end
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (d1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_seen); end
   endtask

`ifdef SHIFT_ROT_SOUT_EN
   task automatic test_sout();
      ld = 1'b1; start = 1'b1; data_in = 16'h0001; mode = 3'd0; amt = 4'd1;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks += 2;
      if (s1 !== 1'b1) begin failures++; $display("FAIL sout_ror: got %b want 1", s1); end
      if (do1 !== 16'h8000) begin failures++; $display("FAIL sout_data: got %h want 8000", do1); end
      wait_idle();
   endtask
`endif

   initial begin
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_ror_step1();
      test_rol_step4();
      test_asr_lsr_step2();
      test_amt_zero();
      test_ignore_in_busy();
`ifdef SHIFT_ROT_SOUT_EN
      test_sout();
`endif
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
